waveform_playback_ctrl: RTL and testbench
=========================================

Name: waveform_playback_ctrl

Overview:
Single-clock sequencer for a 32-bit waveform sample table held in a simple dual-port BRAM.
- Load phase: packs 16-bit host pipe words into 32-bit samples and drives the BRAM write port.
- Playback phase: walks the BRAM read port at a programmable sample period, emitting one sample strobe per period, one-shot or looped.
- Sits between the host pipe endpoint and the waveform consumers (spindle/muscle drive inputs).

Parameters:
ADDR_W, 10, BRAM address width; table depth 2^ADDR_W samples
PERIOD_W, 16, width of the sample-period control

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear  in  1  sync pulse: empty the table, return to IDLE
pipe_in_write  in  1  host pipe halfword valid
pipe_in_data  in  16  host pipe halfword
start  in  1  sync pulse: begin playback
stop  in  1  sync pulse: abort playback
loop_en  in  1  1 = wrap to address 0 after the last sample
period  in  PERIOD_W  clocks per sample; 0 treated as 1
bram_we  out  1  BRAM write enable
bram_waddr  out  ADDR_W  BRAM write address
bram_wdata  out  32  BRAM write data
bram_raddr  out  ADDR_W  BRAM read address
bram_rdata  in  32  BRAM read data, 1-clock registered latency
wave  out  32  current sample, held between strobes
wave_valid  out  1  1-clock strobe per emitted sample
length  out  ADDR_W+1  samples loaded
busy  out  1  high in PLAYING
done  out  1  1-clock pulse at one-shot completion
load_err  out  1  sticky error; cleared by reset or clear

Behaviour:
- Reset: state IDLE; all outputs 0; half-pending flag 0; timer 0.
- All outputs are registered.
- Packing: first halfword of a pair is the upper 16 bits.
  - First halfword: latched, half-pending set.
  - Second halfword: on the next edge bram_we=1, bram_waddr=length, bram_wdata={hi,lo}; length increments on that same edge.
- States:
  - IDLE: length=0. Accepts writes. Moves to LOADED on the first completed word. start is ignored.
  - LOADED: accepts further writes. start with pipe_in_write=0 and stop=0 moves to PLAYING, read address 0, timer 0.
  - PLAYING: pipe writes are dropped and load_err is set.
    - At timer==0 the read is issued at bram_raddr; timer then counts up to max(period,1)-1 and wraps.
    - wave and wave_valid update 2 edges after the read is issued.
    - First wave_valid occurs 3 edges after the edge that samples start; each later one follows max(period,1) clocks after the previous.
  - End of table: after the read of address length-1 is issued:
    - if loop_en=1 (sampled at that edge), the next read is address 0;
    - otherwise the state returns to LOADED after the last wave_valid, done pulses with that wave_valid, and busy falls on the same edge.
- Full: writes arriving when length==2^ADDR_W are dropped and load_err is set.
- A start with half-pending=1 discards the pending halfword and sets load_err.
- stop in PLAYING: state goes to LOADED on the next edge. In-flight reads produce no wave_valid. done is not pulsed. wave holds its value.
- Priority: reset > clear > stop > start.
  - clear zeroes length, half-pending, load_err and timer, and aborts playback with no done pulse.
  - stop and start in the same cycle in LOADED: state is unchanged.
- period is re-sampled at every timer wrap, so changes take effect on the next sample.
- Asynchronous reset mid-write or mid-play: immediate return to reset values; BRAM contents are undefined from the controller's view.

Decomposition:
- Include file waveform_ctrl_defs.vh holds the state encodings (IDLE, LOADED, PLAYING) and the period-zero-as-one rule.
- One sub-module, sample_period_timer: wrapping up-counter with period input and tick output.
- Packing logic and FSM stay in the top module.

Test Plan:
- Load: write halfwords 0,1,0,2,0,3 -> bram writes addr0=0x00000001, addr1=0x00000002, addr2=0x00000003; length=3; state LOADED; load_err=0.
- One-shot playback, period=4, loop_en=0: start -> wave_valid at +3, +7, +11 edges with wave 1, 2, 3; done coincides with the third strobe; busy falls; wave holds 3.
- Looped playback, loop_en=1, period=0: start -> wave_valid every clock with wave 1,2,3,1,2; stop after the 5th strobe -> no further strobes, no done, state LOADED.
- ADDR_W=2: load 5 full words -> length=4, load_err=1, 5th word never written. Then write during PLAYING -> dropped, length unchanged.
- Assert reset asynchronously mid-play, and separately pulse clear together with start -> reset: all outputs 0 immediately; clear-with-start: state IDLE, length=0, no wave_valid; an odd halfword followed by start sets load_err.

Source files
------------

// File: rtl/waveform_playback_ctrl_pkg.sv
// Types shared by the waveform playback controller and its sub-blocks.
package waveform_playback_ctrl_pkg;

`include "waveform_ctrl_defs.vh"

  typedef enum logic [1:0] {
    StIdle    = `WPC_ST_IDLE,
    StLoaded  = `WPC_ST_LOADED,
    StPlaying = `WPC_ST_PLAYING
  } state_e;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;

endpackage

// File: rtl/sample_period_timer.sv
// Wrapping up-counter that paces playback; tick is high while the count is 0.
// The period is captured on clr and at every wrap so changes apply per sample.
`include "waveform_ctrl_defs.vh"

module sample_period_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] last;

  assign last = `WPC_PERIOD_LAST(period_q, PERIOD_W);
  assign tick = (count_q == '0);

  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    if (clr) begin
      count_d  = '0;
      period_d = period;
    end else if (en) begin
      if (count_q >= last) begin
        count_d  = '0;
        period_d = period;
      end else begin
        count_d = count_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      period_q <= '0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/waveform_ctrl_defs.vh
// Shared encodings for the waveform playback controller: FSM state codes and
// the terminal-count rule that makes a programmed period of 0 behave as 1.
`ifndef WAVEFORM_CTRL_DEFS_VH
`define WAVEFORM_CTRL_DEFS_VH

`define WPC_ST_IDLE    2'd0
`define WPC_ST_LOADED  2'd1
`define WPC_ST_PLAYING 2'd2

// Terminal count of the sample timer is max(p, 1) - 1, evaluated at width w.
`define WPC_PERIOD_LAST(p, w) (((p) > w'(1)) ? ((p) - w'(1)) : w'(0))

`endif

// File: rtl/waveform_playback_ctrl.sv
// Waveform table sequencer: packs host halfwords into a 32-bit BRAM table and
// plays the table back at a programmable sample period, one-shot or looped.
module waveform_playback_ctrl
  import waveform_playback_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                pipe_in_write,
  input  logic [HALF_W-1:0]   pipe_in_data,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [PERIOD_W-1:0] period,
  output logic                bram_we,
  output logic [ADDR_W-1:0]   bram_waddr,
  output logic [WORD_W-1:0]   bram_wdata,
  output logic [ADDR_W-1:0]   bram_raddr,
  input  logic [WORD_W-1:0]   bram_rdata,
  output logic [WORD_W-1:0]   wave,
  output logic                wave_valid,
  output logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic                load_err
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e state_q, state_d;

  logic              half_q;
  logic [HALF_W-1:0] hi_q;
  logic [LEN_W-1:0]  len_q;
  logic              err_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [WORD_W-1:0] wdata_q;

  logic [ADDR_W-1:0] raddr_q;
  logic              tail_q;
  // Read pipeline: issue stage marks the BRAM sampling edge, capture stage
  // holds the registered BRAM output one more clock before it reaches wave.
  logic              issue_vld_q, issue_last_q;
  logic              cap_vld_q, cap_last_q;
  logic [WORD_W-1:0] cap_data_q;
  logic [WORD_W-1:0] wave_q;
  logic              wave_valid_q, done_q, busy_q;

  logic             playing, full, flush;
  logic             start_cmd, do_start;
  logic             wr_accept, wr_drop;
  logic             tick, fire, last_read, finish, timer_clr;
  logic [LEN_W-1:0] last_idx;

  always_comb begin
    playing   = (state_q == StPlaying);
    full      = (len_q == FULL_LEN);
    flush     = playing && stop && !clear;
    start_cmd = !clear && !stop && start && !pipe_in_write && !playing;
    do_start  = start_cmd && (state_q == StLoaded);
    wr_accept = !clear && pipe_in_write && !playing && !full;
    wr_drop   = !clear && pipe_in_write && (playing || full);
    last_idx  = len_q - LEN_W'(1);
    last_read = ({1'b0, raddr_q} == last_idx);
    fire      = playing && !clear && !stop && !tail_q && tick;
    finish    = playing && !clear && !stop && cap_vld_q && cap_last_q;
    timer_clr = clear || stop || do_start;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (wr_accept && half_q) state_d = StLoaded;
      StLoaded:  if (do_start) state_d = StPlaying;
      StPlaying: if (stop || finish) state_d = StLoaded;
      default:   state_d = StIdle;
    endcase
    if (clear) state_d = StIdle;
  end

  sample_period_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (playing),
    .period(period),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      half_q       <= 1'b0;
      hi_q         <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      raddr_q      <= '0;
      tail_q       <= 1'b0;
      issue_vld_q  <= 1'b0;
      issue_last_q <= 1'b0;
      cap_vld_q    <= 1'b0;
      cap_last_q   <= 1'b0;
      cap_data_q   <= '0;
      wave_q       <= '0;
      wave_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d == StPlaying);
      we_q         <= 1'b0;
      wave_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (clear) begin
        half_q       <= 1'b0;
        len_q        <= '0;
        err_q        <= 1'b0;
        raddr_q      <= '0;
        tail_q       <= 1'b0;
        issue_vld_q  <= 1'b0;
        issue_last_q <= 1'b0;
        cap_vld_q    <= 1'b0;
        cap_last_q   <= 1'b0;
      end else begin
        if (wr_drop || (start_cmd && half_q)) err_q <= 1'b1;

        // First halfword of a pair is the upper half of the sample.
        if (wr_accept) begin
          if (half_q) begin
            we_q    <= 1'b1;
            waddr_q <= len_q[ADDR_W-1:0];
            wdata_q <= {hi_q, pipe_in_data};
            len_q   <= len_q + LEN_W'(1);
            half_q  <= 1'b0;
          end else begin
            hi_q   <= pipe_in_data;
            half_q <= 1'b1;
          end
        end else if (start_cmd && half_q) begin
          half_q <= 1'b0;
        end

        if (do_start) begin
          raddr_q <= '0;
          tail_q  <= 1'b0;
        end else if (fire) begin
          if (last_read) begin
            raddr_q <= '0;
            tail_q  <= !loop_en;
          end else begin
            raddr_q <= raddr_q + ADDR_W'(1);
          end
        end

        if (flush) begin
          issue_vld_q  <= 1'b0;
          issue_last_q <= 1'b0;
          cap_vld_q    <= 1'b0;
          cap_last_q   <= 1'b0;
        end else begin
          issue_vld_q  <= fire;
          issue_last_q <= fire && last_read && !loop_en;
          cap_vld_q    <= issue_vld_q;
          cap_last_q   <= issue_last_q;
          if (issue_vld_q) cap_data_q <= bram_rdata;
          if (cap_vld_q) begin
            wave_q       <= cap_data_q;
            wave_valid_q <= 1'b1;
            done_q       <= cap_last_q;
          end
        end
      end
    end
  end

  assign bram_we    = we_q;
  assign bram_waddr = waddr_q;
  assign bram_wdata = wdata_q;
  assign bram_raddr = raddr_q;
  assign wave       = wave_q;
  assign wave_valid = wave_valid_q;
  assign length     = len_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_waveform_playback_ctrl.sv
// Scoreboard bench for waveform_playback_ctrl with a 4-entry table and a
// registered-read BRAM model.
module tb_waveform_playback_ctrl;

  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned PERIOD_W = 16;
  localparam int          DEPTH    = 4;

  logic                clk;
  logic                reset;
  logic                clear;
  logic                pipe_in_write;
  logic [15:0]         pipe_in_data;
  logic                start;
  logic                stop;
  logic                loop_en;
  logic [PERIOD_W-1:0] period;
  logic                bram_we;
  logic [ADDR_W-1:0]   bram_waddr;
  logic [31:0]         bram_wdata;
  logic [ADDR_W-1:0]   bram_raddr;
  logic [31:0]         bram_rdata;
  logic [31:0]         wave;
  logic                wave_valid;
  logic [ADDR_W:0]     length;
  logic                busy;
  logic                done;
  logic                load_err;

  waveform_playback_ctrl #(
    .ADDR_W  (ADDR_W),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .pipe_in_write(pipe_in_write),
    .pipe_in_data (pipe_in_data),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .period       (period),
    .bram_we      (bram_we),
    .bram_waddr   (bram_waddr),
    .bram_wdata   (bram_wdata),
    .bram_raddr   (bram_raddr),
    .bram_rdata   (bram_rdata),
    .wave         (wave),
    .wave_valid   (wave_valid),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bram_we) mem[bram_waddr] <= bram_wdata;
    bram_rdata <= mem[bram_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic        done;
  } wv_t;

  wr_t wr_q [$];
  wv_t wv_q [$];
  wr_t wr_e;
  wv_t wv_e;

  logic [31:0] exp_mem [DEPTH];
  int          exp_len = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every BRAM write and every sample strobe against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (bram_we) begin
        if (wr_q.size() == 0) begin
          check_eq("unexpected_write", bram_we, 1'b0);
        end else begin
          wr_e = wr_q.pop_front();
          check_eq("bram_waddr", bram_waddr, wr_e.addr);
          check_eq("bram_wdata", bram_wdata, wr_e.data);
        end
      end
      if (wave_valid) begin
        if (wv_q.size() == 0) begin
          check_eq("unexpected_strobe", wave_valid, 1'b0);
        end else begin
          wv_e = wv_q.pop_front();
          check_eq("strobe_cycle", cyc, wv_e.cyc);
          check_eq("wave", wave, wv_e.data);
          check_eq("done", done, wv_e.done);
        end
      end else if (done) begin
        check_eq("done_without_strobe", done, 1'b0);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put_half(input logic [15:0] h);
    pipe_in_write = 1'b1;
    pipe_in_data  = h;
    cycle();
    pipe_in_write = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w);
    if (exp_len < DEPTH) begin
      wr_q.push_back('{addr: ADDR_W'(exp_len), data: w});
      exp_mem[exp_len] = w;
      exp_len++;
    end
    put_half(w[31:16]);
    put_half(w[15:0]);
  endtask

  task automatic push_strobe(input int c, input logic [31:0] d, input logic dn);
    wv_q.push_back('{cyc: 32'(c), data: d, done: dn});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (wv_q.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
    check_eq({tag, "_drained"}, wv_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [15:0] hi, lo;
    reset = 1'b0; clear = 1'b0; pipe_in_write = 1'b0; pipe_in_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; period = '0;
    #1 reset = 1'b1;
    #1;
    check_eq("rst_wave", wave, 0);
    check_eq("rst_strobes", {wave_valid, done, busy, load_err, bram_we}, 0);
    check_eq("rst_length", length, 0);
    check_eq("rst_addrs", {bram_raddr, bram_waddr}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Load three samples from halfword pairs.
    put_word(32'h0000_0001);
    put_word(32'h0000_0002);
    put_word(32'h0000_0003);
    check_eq("load_length", length, 3);
    check_eq("load_err", load_err, 0);
    check_eq("load_busy", busy, 0);

    // One-shot, period 4.
    period = 4; loop_en = 1'b0;
    n = cyc;
    push_strobe(n + 4,  exp_mem[0], 1'b0);
    push_strobe(n + 8,  exp_mem[1], 1'b0);
    push_strobe(n + 12, exp_mem[2], 1'b1);
    pulse_start();
    check_eq("oneshot_busy", busy, 1);
    wait_drain("oneshot");
    check_eq("oneshot_busy_fell", busy, 0);
    cycle(); cycle();
    check_eq("oneshot_wave_hold", wave, 32'h3);
    check_eq("oneshot_length", length, 3);

    // Looped, period 0 behaves as 1; stop after the fifth strobe.
    period = 0; loop_en = 1'b1;
    n = cyc;
    for (int k = 0; k < 5; k++) push_strobe(n + 4 + k, exp_mem[k % 3], 1'b0);
    pulse_start();
    repeat (7) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    repeat (10) cycle();
    check_eq("loop_drained", wv_q.size(), 0);
    check_eq("loop_busy_after_stop", busy, 0);
    check_eq("loop_wave_hold", wave, exp_mem[1]);

    // Fill the table, then play with a write arriving mid-play.
    put_word(32'h0000_0004);
    check_eq("fill_length", length, 4);
    check_eq("fill_err", load_err, 0);
    period = 2; loop_en = 1'b0;
    n = cyc;
    for (int k = 0; k < 4; k++) push_strobe(n + 4 + 2 * k, exp_mem[k], k == 3);
    pulse_start();
    put_half(16'hBEEF);
    check_eq("play_drop_err", load_err, 1);
    check_eq("play_drop_length", length, 4);
    wait_drain("full_play");
    check_eq("full_play_busy", busy, 0);
    put_word(32'h1234_5678);
    check_eq("full_drop_length", length, 4);

    // Clear, then overfill with five words.
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    exp_len = 0;
    check_eq("clear_length", length, 0);
    check_eq("clear_err", load_err, 0);
    for (int i = 0; i < 5; i++) begin
      hi = 16'hA000 + 16'(i);
      lo = 16'h0500 + 16'(i);
      put_word({hi, lo});
    end
    check_eq("overfill_length", length, 4);
    check_eq("overfill_err", load_err, 1);

    // Asynchronous reset in the middle of looped playback.
    period = 4; loop_en = 1'b1;
    n = cyc;
    push_strobe(n + 4, exp_mem[0], 1'b0);
    push_strobe(n + 8, exp_mem[1], 1'b0);
    pulse_start();
    repeat (8) cycle();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_wave", wave, 0);
    check_eq("arst_strobes", {wave_valid, done, busy, load_err, bram_we}, 0);
    check_eq("arst_length", length, 0);
    check_eq("arst_raddr", bram_raddr, 0);
    check_eq("arst_strobes_seen", wv_q.size(), 0);
    exp_len = 0;
    loop_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // clear together with start returns to IDLE with an empty table.
    put_word(32'h0000_0011);
    put_word(32'h0000_0022);
    check_eq("reload_length", length, 2);
    clear = 1'b1; start = 1'b1;
    cycle();
    clear = 1'b0; start = 1'b0;
    exp_len = 0;
    check_eq("clrstart_length", length, 0);
    check_eq("clrstart_busy", busy, 0);
    repeat (8) cycle();
    pulse_start();
    check_eq("idle_start_ignored", busy, 0);

    // Odd halfword followed by start: pending half discarded, error flagged.
    put_half(16'h00AA);
    pulse_start();
    check_eq("odd_start_err", load_err, 1);
    check_eq("odd_start_busy", busy, 0);
    put_word(32'h0000_BBCC);
    check_eq("after_discard_length", length, 1);

    cycle(); cycle();
    check_eq("writes_drained", wr_q.size(), 0);
    check_eq("strobes_drained", wv_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
